craft_tweakey_stream: RTL
=========================

// Module: craft_tweakey_stream
// PURPOSE
//  Parametrised successor to the nibble-serial CRAFT key register. Streams each round's
//  64-bit tweakey TK[r mod 4] (DW bits/cycle) plus its 8-bit round constant under a
//  valid/ready handshake. Tracks rounds internally and optionally runs rounds in reverse
//  for decryption. Feeds the digit-serial CRAFT round datapath.
// PARAMETERS
//  DW  4   digit width per beat; legal values are 4, 8, 16, 32 and 64; D = 64/DW beats per round
//  NR  32  rounds per block; legal range 4..255
// PORTS
//  clk        in   1   clock, rising edge
//  reset_n    in   1   synchronous active-low reset
//  start      in   1   load request; accepted only when ready=1
//  key        in   128 K0=key[127:64], K1=key[63:0]; sampled on accepted start
//  tweak      in   64  T; sampled on accepted start
//  dec        in   1   1 = reverse round order; sampled on accepted start
//  ready      out  1   idle, able to accept start
//  rk_valid   out  1   rk_out/rc/round are valid
//  rk_ready   in   1   consumer accepts the beat when rk_valid and rk_ready are both 1
//  rk_out     out  DW  current tweakey digit, most significant digit first
//  rc         out  8   round constant {a[3:0],1'b0,b[2:0]}; held for all D beats
//  round      out  8   current round index
//  round_last out  1   current beat is the final digit of the current round
//  done       out  1   one-cycle pulse after the final beat of round NR-1 (enc) or round 0 (dec) is accepted
// BEHAVIOUR
//  - Tweakey words: TK0=K0^T, TK1=K1^T, TK2=K0^Q(T), TK3=K1^Q(T).
//    Q is a nibble permutation, with nibble 0 the MSB: out[i]=T[q[i]],
//    q={12,10,15,5,14,8,9,2,11,3,7,4,6,0,1,13}.
//  - RC LFSRs, forward step: a<={a0^a1,a3,a2,a1}, b<={b0^b1,b2,b1}; reset values a=4'h1, b=3'h1.
//    Inverse step: a<={a2,a1,a0,a3^a0}, b<={b1,b0,b2^b0}.
//  - FSM states: IDLE, PREP, RUN, DONE.
//    IDLE: ready=1. On start, capture key/tweak/dec and set a=1, b=1.
//      If dec=0: round=0, go to RUN.
//      If dec=1: go to PREP.
//    PREP: NR-1 cycles of forward LFSR steps, then round=NR-1, go to RUN.
//    RUN: rk_valid=1. The digit counter advances only on an accepted beat.
//      If rk_ready=0, rk_out/rc/round are held stable.
//      On the accepted beat with round_last=1:
//        enc: round+1 and LFSR forward step.
//        dec: round-1 and LFSR inverse step.
//      On the accepted final beat of the final round, go to DONE.
//    DONE: done=1 for 1 cycle, go to IDLE.
//  - Latency: first beat is valid the cycle after start (enc), or NR cycles after start (dec).
//  - start is ignored while ready=0. key, tweak and dec may change freely after capture.
//  - Digit counter wraps from D-1 to 0. With DW=64, every beat has round_last=1.
//  - Reset (including mid-operation): next cycle is IDLE.
//    Reset values: ready=1, rk_valid=0, done=0, round_last=0, rk_out=0, rc=0, round=0.
//    Any partial round is discarded.
//  - Outputs are registered. There is no combinational path from rk_ready to rk_valid.
// CONFIGURATION
//  CRAFT_TK_DEC_EN defined: dec mode, PREP state and inverse LFSR logic are present.
//  CRAFT_TK_DEC_EN undefined: dec input is ignored and treated as 0; PREP and inverse
//    logic are not built; enc behaviour is identical.
// TESTING
//  1. DW=4, key=128'h27a6781a43f364bc916708d5fbb5aefe, tweak=64'h54cd94ffd0670a58,
//     dec=0, rk_ready=1 -> round0 digits are 7,3,6,b,e,c,e,5,9,3,9,4,6,e,e,4 with rc=8'h11;
//     round1 rc=8'h84, round2 rc=8'h42, round3 rc=8'h25.
//  2. Same key/tweak, DW=8 -> round0 bytes 73,6b,ec,e5,93,94,6e,e4;
//     round_last=1 only on the 8th beat; done pulses exactly once after 32*8 beats.
//  3. Backpressure: rk_ready=0 for 5 cycles mid-round -> rk_out/rc/round are frozen;
//     no beat is lost or duplicated; beat sequence matches scenario 1.
//  4. dec=1 with CRAFT_TK_DEC_EN, NR=32 -> first beat arrives 32 cycles after start with round=31;
//     the rc sequence is the exact reverse of the enc sequence, ending at rc=8'h11 on round 0.
//  5. Assert reset_n=0 mid-round 2 -> next cycle rk_valid=0, ready=1, rc=0;
//     a new start restarts at round 0, digit 0.
//  6. Assert start while RUN -> it is ignored (round, digit and captured key unchanged);
//     start asserted in the same cycle as done=1 is also ignored.

Source files
------------

// File: rtl/craft_tweakey_stream.sv
// rtl/craft_tweakey_stream.sv - digit-serial CRAFT tweakey and round-constant streamer
// Optional reverse-order (decryption) support is built when CRAFT_TK_DEC_EN is defined.
module craft_tweakey_stream #(
    parameter int DW = 4,
    parameter int NR = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [127:0]  key,
    input  logic [63:0]   tweak,
    input  logic          dec,
    output logic          ready,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic [DW-1:0] rk_out,
    output logic [7:0]    rc,
    output logic [7:0]    round,
    output logic          round_last,
    output logic          done
);
    localparam int D   = 64 / DW;
    localparam int DCW = (D > 1) ? $clog2(D) : 1;
    localparam logic [DCW-1:0] DLAST = DCW'(D - 1);
    localparam logic [7:0]     NR_M1 = 8'(NR - 1);
    localparam logic [7:0]     NR_M2 = 8'(NR - 2);
    localparam logic [63:0]    QPERM = 64'hCAF5E892B374601D;

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [63:0]    k0_q, k0_d, k1_q, k1_d, t_q, t_d;
    logic [63:0]    sh_q, sh_d;
    logic [DCW-1:0] dig_q, dig_d;
    logic [7:0]     round_q, round_d;
    logic [3:0]     a_q, a_d;
    logic [2:0]     b_q, b_d;
    logic [7:0]     rc_q, rc_d;
    logic           ready_q, ready_d, valid_q, valid_d, last_q, last_d, done_q, done_d;
    logic           final_round;
    logic [3:0]     a_fwd;
    logic [2:0]     b_fwd;

    function automatic logic [63:0] q_perm(input logic [63:0] t);
        logic [63:0] o;
        int          j;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            j = int'(QPERM[63-4*i -: 4]);
            o[63-4*i -: 4] = t[63-4*j -: 4];
        end
        return o;
    endfunction

    function automatic logic [63:0] tk_sel(input logic [63:0] k0, input logic [63:0] k1,
                                           input logic [63:0] t, input logic [1:0] sel);
        logic [63:0] qt;
        qt = q_perm(t);
        case (sel)
            2'd0:    return k0 ^ t;
            2'd1:    return k1 ^ t;
            2'd2:    return k0 ^ qt;
            default: return k1 ^ qt;
        endcase
    endfunction

    assign a_fwd = {a_q[0] ^ a_q[1], a_q[3], a_q[2], a_q[1]};
    assign b_fwd = {b_q[0] ^ b_q[1], b_q[2], b_q[1]};

`ifdef CRAFT_TK_DEC_EN
    logic       dec_q, dec_d;
    logic [3:0] a_inv;
    logic [2:0] b_inv;
    assign a_inv = {a_q[2], a_q[1], a_q[0], a_q[3] ^ a_q[0]};
    assign b_inv = {b_q[1], b_q[0], b_q[2] ^ b_q[0]};
    assign final_round = dec_q ? (round_q == 8'd0) : (round_q == NR_M1);
`else
    logic unused_dec;
    assign unused_dec  = dec;
    assign final_round = (round_q == NR_M1);
`endif

    always_comb begin
        state_d = state_q;
        k0_d    = k0_q;
        k1_d    = k1_q;
        t_d     = t_q;
        sh_d    = sh_q;
        dig_d   = dig_q;
        round_d = round_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef CRAFT_TK_DEC_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k0_d    = key[127:64];
                    k1_d    = key[63:0];
                    t_d     = tweak;
                    a_d     = 4'h1;
                    b_d     = 3'h1;
                    round_d = 8'd0;
                    dig_d   = '0;
`ifdef CRAFT_TK_DEC_EN
                    dec_d   = dec;
                    if (dec) begin
                        state_d = S_PREP;
                    end else begin
                        state_d = S_RUN;
                        sh_d    = key[127:64] ^ tweak;
                    end
`else
                    state_d = S_RUN;
                    sh_d    = key[127:64] ^ tweak;
`endif
                end
            end
`ifdef CRAFT_TK_DEC_EN
            // Wind the LFSRs forward to the last round's constants; round_q doubles as the counter.
            S_PREP: begin
                a_d     = a_fwd;
                b_d     = b_fwd;
                round_d = round_q + 8'd1;
                if (round_q == NR_M2) begin
                    state_d = S_RUN;
                    sh_d    = tk_sel(k0_q, k1_q, t_q, round_d[1:0]);
                end
            end
`endif
            S_RUN: begin
                if (rk_ready) begin
                    if (dig_q == DLAST) begin
                        dig_d = '0;
                        if (final_round) begin
                            state_d = S_DONE;
                            sh_d    = '0;
                        end else begin
`ifdef CRAFT_TK_DEC_EN
                            if (dec_q) begin
                                round_d = round_q - 8'd1;
                                a_d     = a_inv;
                                b_d     = b_inv;
                            end else begin
                                round_d = round_q + 8'd1;
                                a_d     = a_fwd;
                                b_d     = b_fwd;
                            end
`else
                            round_d = round_q + 8'd1;
                            a_d     = a_fwd;
                            b_d     = b_fwd;
`endif
                            sh_d = tk_sel(k0_q, k1_q, t_q, round_d[1:0]);
                        end
                    end else begin
                        dig_d = dig_q + DCW'(1);
                        sh_d  = sh_q << DW;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered from next-state so rk_ready never reaches them combinationally.
        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_RUN);
        last_d  = valid_d && (dig_d == DLAST);
        done_d  = (state_d == S_DONE);
        rc_d    = valid_d ? {a_d, 1'b0, b_d} : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            k0_q    <= '0;
            k1_q    <= '0;
            t_q     <= '0;
            sh_q    <= '0;
            dig_q   <= '0;
            round_q <= '0;
            a_q     <= 4'h1;
            b_q     <= 3'h1;
            rc_q    <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CRAFT_TK_DEC_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            t_q     <= t_d;
            sh_q    <= sh_d;
            dig_q   <= dig_d;
            round_q <= round_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rc_q    <= rc_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
`ifdef CRAFT_TK_DEC_EN
            dec_q   <= dec_d;
`endif
        end
    end

    assign ready      = ready_q;
    assign rk_valid   = valid_q;
    assign rk_out     = sh_q[63 -: DW];
    assign rc         = rc_q;
    assign round      = round_q;
    assign round_last = last_q;
    assign done       = done_q;

endmodule
